// File: rtl/bcd_counter_scan.sv
// bcd_counter_scan
//   N-digit BCD event/time counter with a programmable prescaler, up/down
//   counting, synchronous clear and parallel load. It also drives a
//   time-multiplexed 7-segment display, with optional leading-zero blanking.
//
// Ports
//   clk       posedge clock
//   rst       synchronous, active-high reset
//   en        count enable (gates prescaler and counting)
//   up        1 = count up, 0 = count down (sampled on the step edge)
//   clr       synchronous clear of prescaler and digits
//   load      synchronous parallel load of load_val (nibbles > 9 clamp to 9)
//   load_val  BCD load value, digit i at [4i+3:4i]
//   prescale  a step occurs every prescale+1 enabled cycles
//   blank_lz  blank leading zeros on the display
//   bcd       current count, digit i at [4i+3:4i]
//   tick      1-cycle pulse on each counter step
//   wrap      1-cycle pulse when a step overflows or underflows
//   seg       {dp,g,f,e,d,c,b,a} for the selected digit; dp always off
//   an        one-hot digit select
module bcd_counter_scan #(
    parameter int DIGITS      = 5,
    parameter int PRESC_W     = 32,
    parameter int SCAN_DIV    = 1024,
    parameter bit SEG_ACT_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic [PRESC_W-1:0]    prescale,
    input  logic                  blank_lz,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  tick,
    output logic                  wrap,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [7:0]        SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] AN_OFF  = SEG_ACT_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    // ------------------------------------------------------------------
    // Counter
    // ------------------------------------------------------------------
    logic [PRESC_W-1:0]  cnt;
    logic [4*DIGITS-1:0] step_val;
    logic [4*DIGITS-1:0] load_clamped;
    logic                step_wrap;
    logic                carry;
    logic [3:0]          digit;

    // Ripple carry/borrow across digits; a carry that survives past the top
    // digit means the step wrapped.
    always_comb begin
        step_val = bcd;
        carry    = 1'b1;
        digit    = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            digit = bcd[4*i +: 4];
            if (carry) begin
                if (up) begin
                    if (digit >= 4'd9) begin
                        step_val[4*i +: 4] = 4'd0;
                    end else begin
                        step_val[4*i +: 4] = digit + 4'd1;
                        carry              = 1'b0;
                    end
                end else begin
                    if (digit == 4'd0) begin
                        step_val[4*i +: 4] = 4'd9;
                    end else begin
                        step_val[4*i +: 4] = digit - 4'd1;
                        carry              = 1'b0;
                    end
                end
            end
        end
        step_wrap = carry;
    end

    always_comb begin
        load_clamped = load_val;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                load_clamped[4*i +: 4] = 4'd9;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            bcd  <= '0;
            tick <= 1'b0;
            wrap <= 1'b0;
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
            if (clr) begin
                cnt <= '0;
                bcd <= '0;
            end else if (load) begin
                cnt <= '0;
                bcd <= load_clamped;
            end else if (en) begin
                // >= so that lowering prescale below cnt steps right away
                if (cnt >= prescale) begin
                    cnt  <= '0;
                    bcd  <= step_val;
                    tick <= 1'b1;
                    wrap <= step_wrap;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan driver
    // ------------------------------------------------------------------
    logic [SCAN_W-1:0] scan_cnt;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        cur_digit;
    logic              all_zero;
    logic              lead_zero;
    logic              blank_now;
    logic [7:0]        seg_low;
    logic [DIGITS-1:0] an_low;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    // Walk from the most-significant digit down; the selected digit is a
    // leading zero if it and every digit above it are zero.
    always_comb begin
        all_zero  = 1'b1;
        lead_zero = 1'b0;
        cur_digit = 4'd0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero & (bcd[4*i +: 4] == 4'd0);
            if (idx == IDX_W'(i)) begin
                lead_zero = all_zero;
                cur_digit = bcd[4*i +: 4];
            end
        end
        blank_now = blank_lz && (idx != '0) && lead_zero;
        seg_low   = blank_now ? 8'hFF : seg7(cur_digit);
        an_low    = ~(DIGITS'(1) << idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
            seg      <= SEG_OFF;
            an       <= AN_OFF;
        end else begin
            if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                idx      <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            seg <= SEG_ACT_LOW ? seg_low : ~seg_low;
            an  <= SEG_ACT_LOW ? an_low  : ~an_low;
        end
    end

endmodule

// File: tb/tb_bcd_counter_scan.sv
module tb_bcd_counter_scan;

    logic        clk = 1'b0;
    logic        rst, en, up, clr, load, blank_lz;
    logic [19:0] load_val;
    logic [31:0] prescale;
    logic [19:0] bcd;
    logic        tick, wrap;
    logic [7:0]  seg;
    logic [4:0]  an;

    int n_assert = 0;
    int n_fail   = 0;

    bcd_counter_scan #(
        .DIGITS(5), .PRESC_W(32), .SCAN_DIV(2), .SEG_ACT_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .prescale(prescale), .blank_lz(blank_lz),
        .bcd(bcd), .tick(tick), .wrap(wrap), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int q;
        rst = 1; en = 0; up = 1; clr = 0; load = 0; blank_lz = 1;
        load_val = '0; prescale = 32'd3;

        // reset state
        cyc();
        chk("rst_bcd", 32'(bcd), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_wrap", 32'(wrap), 32'h0);
        chk("rst_seg", 32'(seg), 32'hFF);
        chk("rst_an", 32'(an), 32'h1F);

        // prescale=3: one step every 4th enabled clock
        rst = 0; en = 1;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            q = k / 4;
            chk("t1_tick", 32'(tick), (k % 4 == 0) ? 32'h1 : 32'h0);
            chk("t1_bcd", 32'(bcd), 32'(((q / 10) << 4) | (q % 10)));
        end
        chk("t1_bcd40", 32'(bcd), 32'h00010);

        // en=0 holds
        en = 0;
        cyc(); cyc(); cyc();
        chk("hold_bcd", 32'(bcd), 32'h00010);
        chk("hold_tick", 32'(tick), 32'h0);

        // load 99999 then overflow
        load_val = 20'h99999; load = 1; en = 1;
        cyc();
        chk("t2_load", 32'(bcd), 32'h99999);
        chk("t2_load_tick", 32'(tick), 32'h0);
        load = 0; prescale = 32'd0;
        cyc();
        chk("t2_ovf_bcd", 32'(bcd), 32'h00000);
        chk("t2_ovf_tick", 32'(tick), 32'h1);
        chk("t2_ovf_wrap", 32'(wrap), 32'h1);

        // underflow, then normal borrow
        up = 0;
        cyc();
        chk("t3_unf_bcd", 32'(bcd), 32'h99999);
        chk("t3_unf_wrap", 32'(wrap), 32'h1);
        chk("t3_unf_tick", 32'(tick), 32'h1);
        cyc();
        chk("t3_dn_bcd", 32'(bcd), 32'h99998);
        chk("t3_dn_wrap", 32'(wrap), 32'h0);
        chk("t3_dn_tick", 32'(tick), 32'h1);

        // clamp on load, then clear while enabled
        load_val = 20'hFA30C; load = 1;
        cyc();
        chk("t4_clamp", 32'(bcd), 32'h99309);
        chk("t4_clamp_tick", 32'(tick), 32'h0);
        load = 0; clr = 1;
        cyc();
        chk("t4_clr_bcd", 32'(bcd), 32'h0);
        chk("t4_clr_tick", 32'(tick), 32'h0);
        chk("t4_clr_wrap", 32'(wrap), 32'h0);
        clr = 0;

        // scan with SCAN_DIV=2, bcd=00042
        en = 0; rst = 1;
        cyc();
        rst = 0; load_val = 20'h00042; load = 1; blank_lz = 1;
        cyc();
        load = 0;
        cyc();
        chk("t5_an_d0", 32'(an), 32'h1E);
        chk("t5_seg_d0", 32'(seg), 32'hA4);
        cyc();
        chk("t5_an_d1", 32'(an), 32'h1D);
        chk("t5_seg_d1", 32'(seg), 32'h99);
        cyc(); cyc();
        chk("t5_an_d2", 32'(an), 32'h1B);
        chk("t5_seg_d2_blank", 32'(seg), 32'hFF);
        cyc(); cyc();
        chk("t5_an_d3", 32'(an), 32'h17);
        chk("t5_seg_d3_blank", 32'(seg), 32'hFF);
        cyc(); cyc();
        chk("t5_an_d4", 32'(an), 32'h0F);
        chk("t5_seg_d4_blank", 32'(seg), 32'hFF);
        cyc(); cyc();
        chk("t5_an_d0b", 32'(an), 32'h1E);
        chk("t5_seg_d0b", 32'(seg), 32'hA4);
        blank_lz = 0;
        cyc(); cyc();
        chk("t5_an_d1b", 32'(an), 32'h1D);
        chk("t5_seg_d1b", 32'(seg), 32'h99);
        cyc(); cyc();
        chk("t5_seg_d2_nb", 32'(seg), 32'hC0);
        cyc(); cyc();
        chk("t5_seg_d3_nb", 32'(seg), 32'hC0);
        cyc(); cyc();
        chk("t5_an_d4b", 32'(an), 32'h0F);
        chk("t5_seg_d4_nb", 32'(seg), 32'hC0);

        // prescale reduced below cnt mid-count
        en = 1; up = 1; prescale = 32'd10; clr = 1;
        cyc();
        clr = 0;
        repeat (7) cyc();
        chk("t6_pre_tick", 32'(tick), 32'h0);
        chk("t6_pre_bcd", 32'(bcd), 32'h0);
        prescale = 32'd2;
        cyc();
        chk("t6_step_tick", 32'(tick), 32'h1);
        chk("t6_step_bcd", 32'(bcd), 32'h1);
        cyc(); cyc();
        chk("t6_gap_tick", 32'(tick), 32'h0);
        cyc();
        chk("t6_next_tick", 32'(tick), 32'h1);
        chk("t6_next_bcd", 32'(bcd), 32'h2);

        // reset mid-scan
        rst = 1;
        cyc();
        chk("t6_rst_seg", 32'(seg), 32'hFF);
        chk("t6_rst_an", 32'(an), 32'h1F);
        chk("t6_rst_bcd", 32'(bcd), 32'h0);
        chk("t6_rst_tick", 32'(tick), 32'h0);
        rst = 0;
        cyc();
        chk("t6_post_an", 32'(an), 32'h1E);
        chk("t6_post_seg", 32'(seg), 32'hC0);
        cyc();
        chk("t6_post_an2", 32'(an), 32'h1E);
        cyc();
        chk("t6_post_an3", 32'(an), 32'h1D);
        chk("t6_post_seg3", 32'(seg), 32'hC0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
